// File: rtl/audio_mix_scaler.sv
// Three-voice audio mixer with 4-bit master volume, saturation and offset-binary
// conversion; one result per tick, held steady for the PWM DAC between updates.
module audio_mix_scaler #(
   parameter int NVOICE = 3,
   parameter int SHIFT  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic [11:0]       voice0,
   input  logic [11:0]       voice1,
   input  logic [11:0]       voice2,
   input  logic [NVOICE-1:0] voice_en,
   input  logic [3:0]        vol,
   output logic [11:0]       sample_out,
   output logic              sample_valid,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [3:0] {
      IDLE, SUM0, SUM1, SUM2, MUL0, MUL1, MUL2, MUL3, SAT
   } state_t;

   localparam logic signed [17:0] CLAMP_MAX = 18'sd2047;
   localparam logic signed [17:0] CLAMP_MIN = -18'sd2048;

   state_t state_q, state_d;

   logic [11:0]        v0_q, v1_q, v2_q;
   logic [NVOICE-1:0]  en_q;
   logic [3:0]         vol_q;
   logic signed [13:0] sum_q;
   logic signed [17:0] prod_q;

   logic [11:0]        sel_voice;
   logic               sel_en;
   logic signed [13:0] sum_addend;
   logic [1:0]         mul_k;
   logic               mul_en;
   logic signed [17:0] sum_ext;
   logic signed [17:0] mul_addend;
   logic signed [17:0] scaled;
   logic signed [11:0] clamped;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (tick) state_d = SUM0;
         SUM0:    state_d = SUM1;
         SUM1:    state_d = SUM2;
         SUM2:    state_d = MUL0;
         MUL0:    state_d = MUL1;
         MUL1:    state_d = MUL2;
         MUL2:    state_d = MUL3;
         MUL3:    state_d = SAT;
         SAT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand selection for the shared adders: one voice per SUM state, one
   // volume bit (and matching left shift of the sum) per MUL state.
   always_comb begin
      sel_voice = 12'd0;
      sel_en    = 1'b0;
      mul_k     = 2'd0;
      mul_en    = 1'b0;
      unique case (state_q)
         SUM0:    begin sel_voice = v0_q; sel_en = en_q[0]; end
         SUM1:    begin sel_voice = v1_q; sel_en = en_q[1]; end
         SUM2:    begin sel_voice = v2_q; sel_en = en_q[2]; end
         MUL0:    begin mul_k = 2'd0; mul_en = vol_q[0]; end
         MUL1:    begin mul_k = 2'd1; mul_en = vol_q[1]; end
         MUL2:    begin mul_k = 2'd2; mul_en = vol_q[2]; end
         MUL3:    begin mul_k = 2'd3; mul_en = vol_q[3]; end
         default: ;
      endcase
      sum_addend = sel_en ? $signed({{2{sel_voice[11]}}, sel_voice}) : 14'sd0;
      sum_ext    = $signed({{4{sum_q[13]}}, sum_q});
      mul_addend = sum_ext <<< mul_k;
   end

   always_comb begin
      scaled = prod_q >>> SHIFT;
      if (scaled > CLAMP_MAX) begin
         clamped = 12'sd2047;
      end else if (scaled < CLAMP_MIN) begin
         clamped = -12'sd2048;
      end else begin
         clamped = scaled[11:0];
      end
   end

   // Adding 2048 to a 12-bit two's-complement value is just an MSB flip.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v0_q         <= 12'd0;
         v1_q         <= 12'd0;
         v2_q         <= 12'd0;
         en_q         <= '0;
         vol_q        <= 4'd0;
         sum_q        <= 14'sd0;
         prod_q       <= 18'sd0;
         sample_out   <= 12'd2048;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         overrun      <= tick && (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  v0_q  <= voice0;
                  v1_q  <= voice1;
                  v2_q  <= voice2;
                  en_q  <= voice_en;
                  vol_q <= vol;
                  sum_q <= 14'sd0;
               end
            end
            SUM0, SUM1: sum_q <= sum_q + sum_addend;
            SUM2: begin
               sum_q  <= sum_q + sum_addend;
               prod_q <= 18'sd0;
            end
            MUL0, MUL1, MUL2, MUL3: begin
               if (mul_en) prod_q <= prod_q + mul_addend;
            end
            SAT: begin
               sample_out   <= {~clamped[11], clamped[10:0]};
               sample_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_audio_mix_scaler.sv
// Self-checking bench for audio_mix_scaler: directed corner cases plus a run of
// random back-to-back mixes compared against an integer reference model.
module tb_audio_mix_scaler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick;
   logic [11:0] voice0, voice1, voice2;
   logic [2:0]  voice_en;
   logic [3:0]  vol;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   audio_mix_scaler #(.NVOICE(3), .SHIFT(5)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .voice0(voice0), .voice1(voice1), .voice2(voice2),
      .voice_en(voice_en), .vol(vol),
      .sample_out(sample_out), .sample_valid(sample_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference: plain integer mix, multiply, floor-divide by 32, clamp, offset.
   function automatic int model(input int v0, input int v1, input int v2,
                                input logic [2:0] en, input int vv);
      int s, p, sc;
      s  = (en[0] ? v0 : 0) + (en[1] ? v1 : 0) + (en[2] ? v2 : 0);
      p  = s * vv;
      sc = p >>> 5;
      if (sc > 2047)  sc = 2047;
      if (sc < -2048) sc = -2048;
      return sc + 2048;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int v0, input int v1, input int v2,
                                input logic [2:0] en, input logic [3:0] vv,
                                input logic t);
      voice0   = 12'(v0);
      voice1   = 12'(v1);
      voice2   = 12'(v2);
      voice_en = en;
      vol      = vv;
      tick     = t;
   endtask

   task automatic scrambleInputs();
      applyStimulus($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048,
                    $urandom_range(0, 4095) - 2048, 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), tick);
   endtask

   task automatic idleCycles(input string tag, input int n, input int held);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checkOutput({tag, " idle valid"}, sample_valid, 0);
         checkOutput({tag, " idle busy"}, busy, 0);
         checkOutput({tag, " idle overrun"}, overrun, 0);
         checkOutput({tag, " idle hold"}, sample_out, held);
      end
   endtask

   // Starts a mix in the current cycle T, scrambles inputs at T+1 and checks
   // busy/valid/hold through T+8 and the result at T+9.
   task automatic runMix(input string tag, input int v0, input int v1, input int v2,
                         input logic [2:0] en, input logic [3:0] vv, output int res);
      int expv, prev;
      expv = model(v0, v1, v2, en, int'(vv));
      prev = int'(sample_out);
      applyStimulus(v0, v1, v2, en, vv, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            tick = 1'b0;
            scrambleInputs();
         end
         checkOutput({tag, " busy"}, busy, 1);
         checkOutput({tag, " valid early"}, sample_valid, 0);
         checkOutput({tag, " overrun"}, overrun, 0);
         checkOutput({tag, " hold"}, sample_out, prev);
      end
      @(negedge clk);
      checkOutput({tag, " valid"}, sample_valid, 1);
      checkOutput({tag, " busy end"}, busy, 0);
      checkOutput({tag, " sample"}, sample_out, expv);
      res = expv;
   endtask

   initial begin
      int r, expv, valid_cnt;
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 3'b000, 4'd0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idleCycles("reset", 20, 2048);

      runMix("v0x8", 1000, 0, 0, 3'b001, 4'd8, r);
      checkOutput("v0x8 literal", sample_out, 2298);
      idleCycles("v0x8", 2, r);
      runMix("posclip", 2047, 2047, 2047, 3'b111, 4'd15, r);
      checkOutput("posclip literal", sample_out, 4095);
      idleCycles("posclip", 1, r);
      runMix("negclip", -2048, -2048, -2048, 3'b111, 4'd15, r);
      checkOutput("negclip literal", sample_out, 0);
      runMix("minus1", -1, 0, 0, 3'b001, 4'd1, r);
      checkOutput("minus1 literal", sample_out, 2047);
      runMix("en0", -1, 1234, -777, 3'b000, 4'd1, r);
      checkOutput("en0 literal", sample_out, 2048);
      runMix("vol0", 2047, 2047, 2047, 3'b111, 4'd0, r);
      checkOutput("vol0 literal", sample_out, 2048);
      runMix("partial", 2000, -1500, 900, 3'b101, 4'd11, r);
      idleCycles("partial", 2, r);

      // Overrun: extra ticks at T+4 and during SAT (T+8) are ignored.
      expv = model(300, -200, 50, 3'b111, 5);
      r = int'(sample_out);
      valid_cnt = 0;
      applyStimulus(300, -200, 50, 3'b111, 4'd5, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (sample_valid === 1'b1) valid_cnt++;
         checkOutput("ovr overrun", overrun, (k == 5 || k == 9) ? 1 : 0);
         checkOutput("ovr busy", busy, (k <= 8) ? 1 : 0);
         checkOutput("ovr sample", sample_out, (k >= 9) ? expv : r);
         if (k == 1) begin
            tick = 1'b0;
            scrambleInputs();
         end
         if (k == 4 || k == 8) tick = 1'b1;
         if (k == 5 || k == 9) tick = 1'b0;
      end
      checkOutput("ovr valid count", valid_cnt, 1);

      // Reset in the middle of a computation discards it.
      valid_cnt = 0;
      applyStimulus(1500, 0, 0, 3'b001, 4'd15, 1'b1);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (sample_valid === 1'b1) valid_cnt++;
         if (k == 1) tick = 1'b0;
         if (k >= 6) begin
            checkOutput("rst sample", sample_out, 2048);
            checkOutput("rst busy", busy, 0);
            checkOutput("rst overrun", overrun, 0);
         end
         if (k == 5) rst_n = 1'b0;
         if (k == 6) rst_n = 1'b1;
      end
      checkOutput("rst valid count", valid_cnt, 0);
      runMix("post rst", 1500, 0, 0, 3'b001, 4'd15, r);

      // Random back-to-back mixes, each started the cycle its predecessor lands.
      for (int n = 0; n < 40; n++) begin
         int a, b, c;
         logic [2:0] e;
         logic [3:0] v;
         a = $urandom_range(0, 4095) - 2048;
         b = $urandom_range(0, 4095) - 2048;
         c = $urandom_range(0, 4095) - 2048;
         e = 3'($urandom_range(0, 7));
         v = 4'($urandom_range(0, 15));
         runMix("rand", a, b, c, e, v, r);
      end
      idleCycles("final", 3, r);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
